// File: rtl/score_display_driver.sv
// -----------------------------------------------------------------------------
// score_display_driver
//   Time-multiplexes the four BCD digits {level10, level1, score10, score1}
//   onto a 4-digit common-anode 7-segment display. Adds pause blinking,
//   level-select blinking, leading-zero blanking and a level-up flash on the
//   decimal point of the level-ones digit.
//
// Ports
//   clk       in   1  system clock
//   rst       in   1  synchronous, active-high reset
//   unpaused  in   1  1 = game running, 0 = paused
//   adj       in   1  1 = level-select mode
//   level10   in   4  level tens digit (BCD)
//   level1    in   4  level ones digit (BCD)
//   score10   in   4  score tens digit (BCD)
//   score1    in   4  score ones digit (BCD)
//   seg       out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp        out  1  decimal point, active-low
//   an        out  4  digit enables, active-low; an[3]=level10 .. an[0]=score1
// -----------------------------------------------------------------------------
module score_display_driver #(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLINK_DIV    = 25000000,
   parameter int unsigned FLASH_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       unpaused,
   input  logic       adj,
   input  logic [3:0] level10,
   input  logic [3:0] level1,
   input  logic [3:0] score10,
   input  logic [3:0] score1,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int unsigned FW = (FLASH_CYCLES * 2 > 1) ? $clog2(FLASH_CYCLES * 2) : 1;

   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
   localparam logic [FW-1:0] FLASH_LOAD   = FW'(FLASH_CYCLES * 2 - 1);

   typedef enum logic [1:0] {
      SLOT_SCORE1  = 2'd0,
      SLOT_SCORE10 = 2'd1,
      SLOT_LEVEL1  = 2'd2,
      SLOT_LEVEL10 = 2'd3
   } slot_e;

   logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
   slot_e         slot_q, slot_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_on_q, blink_on_d;
   logic [FW-1:0] flash_cnt_q, flash_cnt_d;
   logic [7:0]    prev_level_q, prev_level_d;
   logic          unpaused_q, unpaused_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d;
   logic          dp_q, dp_d;

   logic          blink_tick;
   logic          pause_edge;
   logic          blank;
   logic [3:0]    digit;
   logic [3:0]    an_sel;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b0111111;
      endcase
      return s;
   endfunction

   always_comb begin
      refresh_cnt_d = refresh_cnt_q + 1'b1;
      slot_d        = slot_q;
      blink_cnt_d   = blink_cnt_q + 1'b1;
      blink_on_d    = blink_on_q;
      flash_cnt_d   = flash_cnt_q;
      prev_level_d  = {level10, level1};
      unpaused_d    = unpaused;
      digit         = score1;
      an_sel        = 4'b1110;
      blank         = 1'b0;

      // Digit scan
      if (refresh_cnt_q == REFRESH_LAST) begin
         refresh_cnt_d = '0;
         case (slot_q)
            SLOT_SCORE1:  slot_d = SLOT_SCORE10;
            SLOT_SCORE10: slot_d = SLOT_LEVEL1;
            SLOT_LEVEL1:  slot_d = SLOT_LEVEL10;
            default:      slot_d = SLOT_SCORE1;
         endcase
      end

      // Blink timebase; entering pause restarts it in the visible phase
      blink_tick = (blink_cnt_q == BLINK_LAST);
      pause_edge = unpaused_q & ~unpaused;
      if (pause_edge) begin
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end else if (blink_tick) begin
         blink_cnt_d = '0;
         blink_on_d  = ~blink_on_q;
      end

      // Level-up flash counts blink toggles; a fresh change reloads it
      if (!adj && ({level10, level1} != prev_level_q)) begin
         flash_cnt_d = FLASH_LOAD;
      end else if (blink_tick && !pause_edge && (flash_cnt_q != '0)) begin
         flash_cnt_d = flash_cnt_q - 1'b1;
      end

      case (slot_q)
         SLOT_SCORE1:  begin digit = score1;  an_sel = 4'b1110; end
         SLOT_SCORE10: begin digit = score10; an_sel = 4'b1101; end
         SLOT_LEVEL1:  begin digit = level1;  an_sel = 4'b1011; end
         default:      begin digit = level10; an_sel = 4'b0111; end
      endcase

      // Blink blanking first, then leading-zero blanking outside level-select
      if (adj) begin
         blank = ((slot_q == SLOT_LEVEL10) || (slot_q == SLOT_LEVEL1)) && !blink_on_q;
      end else begin
         blank = (!unpaused && !blink_on_q)
               || ((slot_q == SLOT_LEVEL10) && (level10 == 4'd0))
               || ((slot_q == SLOT_SCORE10) && (score10 == 4'd0));
      end

      seg_d = seg_decode(digit);
      an_d  = blank ? '1 : an_sel;
      dp_d  = !((flash_cnt_q != '0) && blink_on_q && (slot_q == SLOT_LEVEL1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt_q <= '0;
         slot_q        <= SLOT_SCORE1;
         blink_cnt_q   <= '0;
         blink_on_q    <= 1'b1;
         flash_cnt_q   <= '0;
         prev_level_q  <= '0;
         unpaused_q    <= 1'b0;
         seg_q         <= '1;
         an_q          <= '1;
         dp_q          <= 1'b1;
      end else begin
         refresh_cnt_q <= refresh_cnt_d;
         slot_q        <= slot_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_on_q    <= blink_on_d;
         flash_cnt_q   <= flash_cnt_d;
         prev_level_q  <= prev_level_d;
         unpaused_q    <= unpaused_d;
         seg_q         <= seg_d;
         an_q          <= an_d;
         dp_q          <= dp_d;
      end
   end

   assign seg = seg_q;
   assign an  = an_q;
   assign dp  = dp_q;

endmodule
